// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: issues in-order imem requests from the PC register,
// buffers up to two responses for decode and discards stale responses after a redirect.
module fetch_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc_current,
    output logic [ADDR_WIDTH-1:0] pc_next,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [DATA_WIDTH-1:0] if_instr
);

    logic [ADDR_WIDTH-1:0] fifo_pc [2];
    logic                  fifo_rd;
    logic                  fifo_wr;
    logic [1:0]            fifo_cnt;

    logic [ADDR_WIDTH-1:0] buf_pc    [2];
    logic [DATA_WIDTH-1:0] buf_instr [2];
    logic                  buf_rd;
    logic                  buf_wr;
    logic [1:0]            buf_cnt;

    logic [1:0]            drop_cnt;
    logic [1:0]            drop_next;
    logic [2:0]            pending;
    logic [2:0]            occ;
    logic [2:0]            occ_after_pop;
    logic                  pop;
    logic                  issue;
    logic                  rsp_drop;
    logic                  rsp_write;
    logic                  unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Credit check counts stale in-flight responses too, and lets a same-cycle pop free a slot.
    assign occ            = {1'b0, fifo_cnt} + {1'b0, drop_cnt} + {1'b0, buf_cnt};
    assign pop            = if_valid && if_ready;
    assign occ_after_pop  = occ - {2'b00, pop};
    assign imem_req_valid = !rst && !redirect_valid && (occ_after_pop < 3'd2);
    assign issue          = imem_req_valid && imem_req_ready;
    assign imem_req_addr  = pc_current;

    assign rsp_drop  = imem_rsp_valid && !redirect_valid && (drop_cnt != 2'd0);
    assign rsp_write = imem_rsp_valid && !redirect_valid && (drop_cnt == 2'd0) && (fifo_cnt != 2'd0);

    always_comb begin
        pc_next = pc_current;
        if (rst) begin
            pc_next = pc_current;
        end else if (redirect_valid) begin
            pc_next = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        end else if (issue) begin
            pc_next = pc_current + ADDR_WIDTH'(4);
        end
    end

    // Everything still in flight becomes stale; a response landing this cycle is one of them.
    always_comb begin
        pending   = {1'b0, drop_cnt} + {1'b0, fifo_cnt};
        drop_next = pending[1:0];
        if (imem_rsp_valid && (pending != 3'd0)) begin
            drop_next = 2'(pending - 3'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_rd  <= 1'b0;
            fifo_wr  <= 1'b0;
            fifo_cnt <= 2'd0;
            buf_rd   <= 1'b0;
            buf_wr   <= 1'b0;
            buf_cnt  <= 2'd0;
            drop_cnt <= 2'd0;
        end else if (redirect_valid) begin
            fifo_rd  <= 1'b0;
            fifo_wr  <= 1'b0;
            fifo_cnt <= 2'd0;
            buf_rd   <= 1'b0;
            buf_wr   <= 1'b0;
            buf_cnt  <= 2'd0;
            drop_cnt <= drop_next;
        end else begin
            if (issue) begin
                fifo_wr <= ~fifo_wr;
            end
            if (rsp_write) begin
                fifo_rd <= ~fifo_rd;
                buf_wr  <= ~buf_wr;
            end
            if (pop) begin
                buf_rd <= ~buf_rd;
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - 2'd1;
            end
            fifo_cnt <= fifo_cnt + {1'b0, issue} - {1'b0, rsp_write};
            buf_cnt  <= buf_cnt + {1'b0, rsp_write} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            fifo_pc[fifo_wr] <= pc_current;
        end
        if (rsp_write) begin
            buf_pc[buf_wr]    <= fifo_pc[fifo_rd];
            buf_instr[buf_wr] <= imem_rsp_data;
        end
    end

    // Head is zeroed while empty so reset shows clean outputs without resetting the data array.
    assign if_valid = (buf_cnt != 2'd0);
    assign if_pc    = if_valid ? buf_pc[buf_rd]    : '0;
    assign if_instr = if_valid ? buf_instr[buf_rd] : '0;

    rsp_without_request: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && (occ == 3'd0)));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: PC register and latency-programmable memory around the DUT,
// a queue-based model of the delivered stream, and directed scenarios with literal pins.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_current;
    logic [31:0] pc_next;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    logic        pc_force;
    logic [31:0] pc_force_val;

    fetch_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .pc_current(pc_current), .pc_next(pc_next),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_pc(if_pc), .if_instr(if_instr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pc_current <= pc_force ? pc_force_val : pc_next;

    typedef struct { logic [31:0] addr; int due; bit live; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    mreq_t       memq[$];
    ent_t        expq[$];
    logic [31:0] pop_pc[$];
    int          pop_cyc[$];
    int          cyc;
    int          lat;
    int          n_pass;
    int          n_total;
    logic [31:0] snap_pc_next;
    logic        snap_rsp;
    logic        snap_issue;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] pop_at(input int i);
        return (pop_pc.size() > i) ? pop_pc[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic mem_drive();
        if (rst) begin
            imem_rsp_valid = 1'($urandom);
            imem_rsp_data  = $urandom;
        end else if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(memq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    // Model: expq is what decode must see next; memq is every request still owed by memory.
    task automatic model_step();
        int          buffered;
        int          occ;
        bit          pop;
        bit          req;
        bit          iss;
        logic [31:0] epc;
        mreq_t       m;
        if (rst) begin
            memq.delete();
            expq.delete();
        end
        buffered = expq.size();
        pop      = (buffered > 0) && if_ready;
        occ      = memq.size() + buffered;
        req      = !rst && !redirect_valid && ((occ - int'(pop)) < 2);
        iss      = req && imem_req_ready;
        if (rst)                 epc = pc_current;
        else if (redirect_valid) epc = redirect_pc & ~32'h3;
        else if (iss)            epc = pc_current + 32'd4;
        else                     epc = pc_current;

        check("if_valid", 32'(if_valid), 32'(buffered > 0));
        if (buffered > 0) begin
            check("if_pc", if_pc, expq[0].pc);
            check("if_instr", if_instr, expq[0].instr);
        end else if (rst) begin
            check("if_pc_reset", if_pc, 32'h0);
            check("if_instr_reset", if_instr, 32'h0);
        end
        check("imem_req_valid", 32'(imem_req_valid), 32'(req));
        check("imem_req_addr", imem_req_addr, pc_current);
        check("pc_next", pc_next, epc);

        snap_pc_next = pc_next;
        snap_rsp     = imem_rsp_valid;
        snap_issue   = imem_req_valid && imem_req_ready;
        if (!rst && if_valid && if_ready) begin
            pop_pc.push_back(if_pc);
            pop_cyc.push_back(cyc);
        end

        if (!rst) begin
            if (pop) void'(expq.pop_front());
            if (imem_rsp_valid && memq.size() > 0) begin
                m = memq.pop_front();
                if (m.live && !redirect_valid) expq.push_back('{m.addr, mem_word(m.addr)});
            end
            if (redirect_valid) begin
                expq.delete();
                foreach (memq[i]) memq[i].live = 1'b0;
            end
            if (iss) memq.push_back('{pc_current, cyc + lat, 1'b1});
        end
        cyc++;
    endtask

    // Caller drives inputs at posedge+1, then calls cycle(); returns at the next posedge+1.
    task automatic cycle();
        #2;
        mem_drive();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        rst            = 1'b1;
        pc_force       = 1'b1;
        pc_force_val   = start_pc;
        redirect_valid = 1'b0;
        repeat (2) cycle();
        rst      = 1'b0;
        pc_force = 1'b0;
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        int k = 0;
        while (pop_pc.size() < n && k < budget) begin
            cycle();
            k++;
        end
        check(name, 32'(pop_pc.size() >= n), 32'd1);
    endtask

    initial begin
        int          rel;
        int          t;
        int          k;
        logic [31:0] saved;
        n_pass = 0; n_total = 0; cyc = 0; lat = 1;
        rst = 1'b1; pc_force = 1'b1; pc_force_val = 32'h0;
        redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b1; if_ready = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        @(posedge clk); #1;

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            redirect_valid = 1'($urandom);
            redirect_pc    = $urandom;
            imem_req_ready = 1'($urandom);
            if_ready       = 1'($urandom);
            cycle();
        end
        check("reset_req_valid", 32'(imem_req_valid), 32'd0);
        check("reset_if_valid", 32'(if_valid), 32'd0);
        check("reset_pc_next_hold", pc_next, pc_current);

        // Straight-line fetch, 1-cycle memory
        rst = 1'b0; pc_force = 1'b0; redirect_valid = 1'b0;
        imem_req_ready = 1'b1; if_ready = 1'b1;
        pop_pc.delete(); pop_cyc.delete();
        rel = cyc;
        repeat (8) cycle();
        check("line_pc0", pop_at(0), 32'h0);
        check("line_pc1", pop_at(1), 32'h4);
        check("line_pc2", pop_at(2), 32'h8);
        check("line_pc3", pop_at(3), 32'hC);
        check("line_instr_latency", (pop_cyc.size() > 3) ? 32'(pop_cyc[0] - rel) : 32'hFFFF, 32'd2);
        check("line_back_to_back", (pop_cyc.size() > 3) ? 32'(pop_cyc[3] - pop_cyc[0]) : 32'hFFFF, 32'd3);

        // Decode back-pressure
        do_reset(32'h0);
        if_ready = 1'b0;
        repeat (5) cycle();
        check("bp_head_valid", 32'(if_valid), 32'd1);
        check("bp_head_pc", if_pc, 32'h0);
        check("bp_head_instr", if_instr, mem_word(32'h0));
        check("bp_req_dropped", 32'(imem_req_valid), 32'd0);
        pop_pc.delete(); pop_cyc.delete();
        if_ready = 1'b1;
        repeat (6) cycle();
        check("bp_order0", pop_at(0), 32'h0);
        check("bp_order1", pop_at(1), 32'h4);
        check("bp_order2", pop_at(2), 32'h8);

        // Redirect with two requests in flight, 3-cycle memory
        lat = 3;
        do_reset(32'h0);
        repeat (2) cycle();
        check("redir_two_outstanding", 32'(memq.size()), 32'd2);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        cycle();
        redirect_valid = 1'b0;
        pop_pc.delete(); pop_cyc.delete();
        wait_pops(2, 25, "redir_delivery_timeout");
        check("redir_first_pc", pop_at(0), 32'h100);
        check("redir_second_pc", pop_at(1), 32'h104);

        // Redirect coincident with a response, 1-cycle memory
        lat = 1;
        repeat (4) cycle();
        k = 0;
        while (!(memq.size() > 0 && memq[0].due <= cyc) && k < 10) begin
            cycle();
            k++;
        end
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        t = cyc;
        cycle();
        redirect_valid = 1'b0;
        check("coinc_rsp_present", 32'(snap_rsp), 32'd1);
        check("coinc_pc_next", snap_pc_next, 32'h200);
        pop_pc.delete(); pop_cyc.delete();
        wait_pops(1, 10, "coinc_delivery_timeout");
        check("coinc_first_pc", pop_at(0), 32'h200);
        check("coinc_latency", (pop_cyc.size() > 0) ? 32'(pop_cyc[0] - t) : 32'hFFFF, 32'd3);

        // Memory stall holds the PC
        imem_req_ready = 1'b0;
        saved = pc_current;
        repeat (3) cycle();
        check("stall_pc_hold", pc_current, saved);
        check("stall_pc_next", pc_next, saved);
        check("stall_req_addr", imem_req_addr, saved);
        imem_req_ready = 1'b1;
        repeat (3) cycle();

        // Address wrap
        do_reset(32'hFFFF_FFFC);
        pop_pc.delete(); pop_cyc.delete();
        cycle();
        check("wrap_issue", 32'(snap_issue), 32'd1);
        check("wrap_pc_next", snap_pc_next, 32'h0);
        repeat (4) cycle();
        check("wrap_pop0", pop_at(0), 32'hFFFF_FFFC);
        check("wrap_pop1", pop_at(1), 32'h0);

        // Mixed random stalls and redirects, 2-cycle memory
        lat = 2;
        for (int i = 0; i < 60; i++) begin
            if_ready       = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc    = $urandom;
            cycle();
        end
        redirect_valid = 1'b0;

        // Reset in the middle of a stream
        if_ready = 1'b1; imem_req_ready = 1'b1;
        do_reset(32'h40);
        pop_pc.delete(); pop_cyc.delete();
        wait_pops(2, 12, "midreset_delivery_timeout");
        check("midreset_pc0", pop_at(0), 32'h40);
        check("midreset_pc1", pop_at(1), 32'h44);
        repeat (3) cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
